// File: rtl/bcd_timer_core_pkg.sv
// -----------------------------------------------------------------------------
// packs -- shared types and constants for the MM:SS BCD timer.
//   BCDnumber_t   : one 4-bit BCD digit
//   state_t       : timer FSM states IDLE / RUN / PAUSE / DONE
//   *_MAX         : highest legal value of each digit position
//   bcd_clamp()   : saturates an out-of-range digit to its position maximum
// -----------------------------------------------------------------------------
package packs;

    typedef logic [3:0] BCDnumber_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int unsigned SEC_TENS_MAX = 5;
    localparam int unsigned MIN_TENS_MAX = 5;
    localparam int unsigned UNITS_MAX    = 9;

    function automatic BCDnumber_t bcd_clamp(input BCDnumber_t d, input BCDnumber_t max);
        return (d > max) ? max : d;
    endfunction

endpackage

// File: rtl/bcd_timer_core_digit_cnt.sv
// -----------------------------------------------------------------------------
// bcd_digit_cnt -- one BCD digit of the timer ripple chain.
//   clk, rst_n : clock, synchronous active-low reset (q -> 0)
//   en         : step this digit by one this cycle
//   up         : 1 = increment (wrap MAX->0), 0 = decrement (wrap 0->MAX)
//   load, d    : synchronous parallel load, wins over en
//   q          : current digit value
//   carry      : combinational; high when this step wraps, used as en of the
//                next digit so a carry/borrow ripples within the same cycle
// -----------------------------------------------------------------------------
module bcd_digit_cnt
    import packs::*;
#(
    parameter int unsigned MAX = UNITS_MAX
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       up,
    input  logic       load,
    input  BCDnumber_t d,
    output BCDnumber_t q,
    output logic       carry
);

    localparam BCDnumber_t L_MAX = BCDnumber_t'(MAX);

    BCDnumber_t r_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_q <= '0;
        end else if (load) begin
            r_q <= d;
        end else if (en) begin
            if (up) begin
                r_q <= (r_q == L_MAX) ? '0 : r_q + 4'd1;
            end else begin
                r_q <= (r_q == '0) ? L_MAX : r_q - 4'd1;
            end
        end
    end

    assign carry = en && !load && (up ? (r_q == L_MAX) : (r_q == '0));
    assign q     = r_q;

endmodule

// File: rtl/bcd_timer_core.sv
// -----------------------------------------------------------------------------
// bcd_timer_core -- MM:SS stopwatch / countdown timer with BCD outputs.
//   clk, rst_n  : clock, synchronous active-low reset
//   tick        : one-cycle prescaler enable; TICK_DIV ticks = one second
//   start_stop  : button level, rising edge starts / pauses / resumes
//   clear       : button level, rising edge returns to IDLE with 00:00
//   preset      : countdown start value {M-tens, M-units, S-tens, S-units}
//   num         : registered current value, same digit order
//   running     : high while in RUN
//   done        : one-cycle pulse on terminal count
// Compile-time option: define TIMER_COUNTDOWN_EN for countdown mode
// (load preset on start, stop in DONE at 00:00); otherwise counts up and
// wraps 59:59 -> 00:00 with a done pulse.
// -----------------------------------------------------------------------------
module bcd_timer_core
    import packs::*;
#(
    parameter int unsigned NRO_DIGITOS = 4,
    parameter int unsigned TICK_DIV    = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          tick,
    input  logic                          start_stop,
    input  logic                          clear,
    input  BCDnumber_t [NRO_DIGITOS-1:0]  preset,
    output BCDnumber_t [NRO_DIGITOS-1:0]  num,
    output logic                          running,
    output logic                          done
);

`ifdef TIMER_COUNTDOWN_EN
    localparam bit L_UP = 1'b0;
`else
    localparam bit L_UP = 1'b1;
`endif

    state_t           r_state;
    state_t           w_next_state;
    logic             r_ss_d;
    logic             r_clr_d;
    logic             r_ss_blk;
    logic             r_clr_blk;
    logic             w_ss_edge;
    logic             w_clr_edge;
    logic [7:0]       r_presc;
    logic             w_presc_last;
    logic             w_step;
    logic             w_start;
    logic             w_load;
    logic             w_term;
    logic             w_preset_zero;
    logic             w_done_set;
    logic             r_done;
    BCDnumber_t [3:0] w_load_val;
    BCDnumber_t [3:0] w_q;
    logic [3:0]       w_en;
    logic [3:0]       w_carry;

    // Button edge detection. The edge registers clear on reset; r_*_blk
    // additionally masks a level that was already high during reset until
    // it has been seen low, so a held button does not fire on release.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ss_d    <= 1'b0;
            r_clr_d   <= 1'b0;
            r_ss_blk  <= start_stop;
            r_clr_blk <= clear;
        end else begin
            r_ss_d    <= start_stop;
            r_clr_d   <= clear;
            r_ss_blk  <= r_ss_blk & start_stop;
            r_clr_blk <= r_clr_blk & clear;
        end
    end

    assign w_ss_edge  = start_stop & ~r_ss_d & ~r_ss_blk;
    assign w_clr_edge = clear & ~r_clr_d & ~r_clr_blk;

    // Priority clear > start_stop > tick: a tick is consumed only when no
    // button edge is acting in the same cycle.
    assign w_start      = w_ss_edge && !w_clr_edge && (r_state == IDLE);
    assign w_presc_last = (r_presc == 8'(TICK_DIV - 1));
    assign w_step       = (r_state == RUN) && tick && !w_clr_edge && !w_ss_edge && w_presc_last;

`ifdef TIMER_COUNTDOWN_EN
    BCDnumber_t [3:0] w_preset_cl;
    logic             w_unused_carry;

    assign w_preset_cl[3]  = bcd_clamp(preset[3], BCDnumber_t'(MIN_TENS_MAX));
    assign w_preset_cl[2]  = bcd_clamp(preset[2], BCDnumber_t'(UNITS_MAX));
    assign w_preset_cl[1]  = bcd_clamp(preset[1], BCDnumber_t'(SEC_TENS_MAX));
    assign w_preset_cl[0]  = bcd_clamp(preset[0], BCDnumber_t'(UNITS_MAX));
    assign w_preset_zero   = (w_preset_cl == '0);
    assign w_load_val      = w_clr_edge ? '0 : w_preset_cl;
    // The decrement from 00:01 is the one that lands on 00:00.
    assign w_term          = w_step && (w_q == 16'h0001);
    assign w_unused_carry  = w_carry[3];
`else
    logic w_unused_preset;

    assign w_preset_zero   = 1'b0;
    assign w_load_val      = '0;
    // Carry out of minutes-tens means 59:59 just wrapped to 00:00.
    assign w_term          = w_carry[3];
    assign w_unused_preset = ^preset;
`endif

    // FSM: state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM: next state
    always_comb begin
        w_next_state = r_state;
        if (w_clr_edge) begin
            w_next_state = IDLE;
        end else if (w_ss_edge) begin
            unique case (r_state)
                IDLE:    w_next_state = w_preset_zero ? DONE : RUN;
                RUN:     w_next_state = PAUSE;
                PAUSE:   w_next_state = RUN;
                DONE:    w_next_state = DONE;
                default: w_next_state = r_state;
            endcase
        end else if (w_term && !L_UP) begin
            w_next_state = DONE;
        end
    end

    // FSM: outputs and datapath controls
    always_comb begin
        running    = (r_state == RUN);
        w_load     = w_clr_edge || w_start;
        w_done_set = (w_start && w_preset_zero) || w_term;
    end

    // Prescaler: zeroed on clear and on IDLE->RUN, held while paused.
    always_ff @(posedge clk) begin
        if (!rst_n || w_clr_edge || w_start) begin
            r_presc <= '0;
        end else if ((r_state == RUN) && tick && !w_ss_edge) begin
            r_presc <= w_presc_last ? '0 : r_presc + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_done <= 1'b0;
        end else begin
            r_done <= w_done_set;
        end
    end

    assign done = r_done;

    assign w_en = {w_carry[2:0], w_step};

    bcd_digit_cnt #(.MAX(UNITS_MAX)) u_sec_units (
        .clk(clk), .rst_n(rst_n), .en(w_en[0]), .up(L_UP), .load(w_load),
        .d(w_load_val[0]), .q(w_q[0]), .carry(w_carry[0])
    );

    bcd_digit_cnt #(.MAX(SEC_TENS_MAX)) u_sec_tens (
        .clk(clk), .rst_n(rst_n), .en(w_en[1]), .up(L_UP), .load(w_load),
        .d(w_load_val[1]), .q(w_q[1]), .carry(w_carry[1])
    );

    bcd_digit_cnt #(.MAX(UNITS_MAX)) u_min_units (
        .clk(clk), .rst_n(rst_n), .en(w_en[2]), .up(L_UP), .load(w_load),
        .d(w_load_val[2]), .q(w_q[2]), .carry(w_carry[2])
    );

    bcd_digit_cnt #(.MAX(MIN_TENS_MAX)) u_min_tens (
        .clk(clk), .rst_n(rst_n), .en(w_en[3]), .up(L_UP), .load(w_load),
        .d(w_load_val[3]), .q(w_q[3]), .carry(w_carry[3])
    );

    assign num = w_q;

endmodule

// File: tb/tb_bcd_timer_core.sv
// -----------------------------------------------------------------------------
// Testbench for bcd_timer_core. Two instances (TICK_DIV=1 and TICK_DIV=4)
// share the same stimulus. A reference model that tracks the time as a
// plain number of seconds predicts each cycle's outputs; the driver pushes
// predictions into a queue and a separate monitor compares them.
// -----------------------------------------------------------------------------
module tb_bcd_timer_core;

`ifdef TIMER_COUNTDOWN_EN
    localparam bit CD = 1'b1;
`else
    localparam bit CD = 1'b0;
`endif

    typedef struct {
        int st;          // 0 idle, 1 run, 2 pause, 3 done
        int secs;
        int presc;
        bit done;
        bit prev_ss;
        bit prev_clr;
        bit arm_ss;      // button has been seen low since reset
        bit arm_clr;
    } model_t;

    typedef struct {
        int          due;
        logic [15:0] num1;
        logic [15:0] num4;
        bit          run1;
        bit          run4;
        bit          done1;
        bit          done4;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        tick = 1'b0;
    logic        start_stop = 1'b0;
    logic        clear = 1'b0;
    logic [15:0] preset = '0;
    logic [15:0] num1;
    logic [15:0] num4;
    logic        running1, running4, done1, done4;

    logic [15:0] pv = '0;
    int          cyc = 0;
    int          tests = 0;
    int          fails = 0;
    exp_t        sb[$];
    model_t      m1, m4;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    bcd_timer_core #(.NRO_DIGITOS(4), .TICK_DIV(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .tick(tick), .start_stop(start_stop), .clear(clear),
        .preset(preset), .num(num1), .running(running1), .done(done1)
    );

    bcd_timer_core #(.NRO_DIGITOS(4), .TICK_DIV(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .tick(tick), .start_stop(start_stop), .clear(clear),
        .preset(preset), .num(num4), .running(running4), .done(done4)
    );

    function automatic int clampd(input int d, input int mx);
        return (d > mx) ? mx : d;
    endfunction

    function automatic int preset_secs(input logic [15:0] p);
        int mins, secs;
        mins = clampd(int'(p[15:12]), 5) * 10 + clampd(int'(p[11:8]), 9);
        secs = clampd(int'(p[7:4]), 5) * 10 + clampd(int'(p[3:0]), 9);
        return mins * 60 + secs;
    endfunction

    function automatic logic [15:0] to_bcd(input int s);
        int mm, ss;
        mm = s / 60;
        ss = s % 60;
        return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
    endfunction

    function automatic model_t mstep(input model_t m, input bit rn, input bit ss, input bit clr,
                                     input bit tk, input logic [15:0] pre, input int div);
        model_t n;
        bit     sse, clre;
        int     v;
        n = m;
        n.done = 1'b0;
        if (!rn) begin
            n.st = 0; n.secs = 0; n.presc = 0;
            n.prev_ss = 1'b0; n.prev_clr = 1'b0;
            n.arm_ss = !ss; n.arm_clr = !clr;
            return n;
        end
        sse  = ss && !m.prev_ss && m.arm_ss;
        clre = clr && !m.prev_clr && m.arm_clr;
        n.prev_ss  = ss;
        n.prev_clr = clr;
        n.arm_ss   = m.arm_ss || !ss;
        n.arm_clr  = m.arm_clr || !clr;
        if (clre) begin
            n.st = 0; n.secs = 0; n.presc = 0;
        end else if (sse) begin
            case (m.st)
                0: begin
                    n.presc = 0;
                    if (CD) begin
                        v = preset_secs(pre);
                        n.secs = v;
                        if (v == 0) begin n.st = 3; n.done = 1'b1; end
                        else n.st = 1;
                    end else begin
                        n.st = 1;
                    end
                end
                1: n.st = 2;
                2: n.st = 1;
                default: n.st = m.st;
            endcase
        end else if (m.st == 1 && tk) begin
            n.presc = m.presc + 1;
            if (n.presc == div) begin
                n.presc = 0;
                if (CD) begin
                    n.secs = m.secs - 1;
                    if (n.secs == 0) begin n.st = 3; n.done = 1'b1; end
                end else begin
                    n.secs = (m.secs + 1) % 3600;
                    if (n.secs == 0) n.done = 1'b1;
                end
            end
        end
        return n;
    endfunction

    // Apply one cycle of inputs and push the outputs expected after the next edge.
    task automatic drive(input bit rn, input bit ss, input bit clr, input bit tk);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n = rn; start_stop = ss; clear = clr; tick = tk; preset = pv;
        m1 = mstep(m1, rn, ss, clr, tk, pv, 1);
        m4 = mstep(m4, rn, ss, clr, tk, pv, 4);
        e.due   = cyc + 1;
        e.num1  = to_bcd(m1.secs);
        e.num4  = to_bcd(m4.secs);
        e.run1  = (m1.st == 1);
        e.run4  = (m4.st == 1);
        e.done1 = m1.done;
        e.done4 = m4.done;
        sb.push_back(e);
    endtask

    task automatic ticks(input int n);
        repeat (n) drive(1'b1, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic press_ss();
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic press_clr();
        drive(1'b1, 1'b0, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", nm, cyc, act, exp);
        end
    endtask

    // Monitor: the DUT presents fresh outputs every cycle; compare at negedge.
    always @(negedge clk) begin
        exp_t e;
        while (sb.size() > 0 && sb[0].due == cyc) begin
            e = sb.pop_front();
            chk("num_div1",     num1,            e.num1);
            chk("running_div1", 16'(running1),   16'(e.run1));
            chk("done_div1",    16'(done1),      16'(e.done1));
            chk("num_div4",     num4,            e.num4);
            chk("running_div4", 16'(running4),   16'(e.run4));
            chk("done_div4",    16'(done4),      16'(e.done4));
        end
    end

    initial begin
        bit ss_l, clr_l, rn, tk;

        // Reset state
        repeat (3) drive(1'b0, 1'b0, 1'b0, 1'b0);
        idle(1);

        // Start then 60 ticks: 01:00 in count-up
        press_ss();
        ticks(60);

        // Pause sequence: 5 ticks, pause, 10 dropped ticks, resume, 3 ticks
        press_clr();
        press_ss();
        ticks(5);
        press_ss();
        ticks(10);
        press_ss();
        ticks(3);

        // Wrap at 59:59 (count-up) / long countdown from 59:59
        press_clr();
        pv = 16'h5959;
        press_ss();
        ticks(3598);
        ticks(2);
        idle(2);

        // clear + start_stop + tick rising together while running at 12:34
        press_clr();
        pv = 16'h5959;
        press_ss();
        ticks(754);
        drive(1'b1, 1'b1, 1'b1, 1'b1);
        idle(2);

        // Countdown from 00:03, start ignored in DONE, clear back to IDLE
        pv = 16'h0003;
        press_ss();
        ticks(3);
        press_ss();
        ticks(2);
        press_clr();

        // Zero preset, out-of-range preset digits
        pv = 16'h0000;
        press_ss();
        idle(2);
        press_clr();
        pv = 16'h7C9F;
        press_ss();
        ticks(7);
        press_clr();

        // Prescaler: 7 ticks give one update on the TICK_DIV=4 instance
        pv = 16'h0030;
        press_ss();
        ticks(7);
        idle(1);

        // Reset mid-run with start_stop held high through reset
        drive(1'b0, 1'b1, 1'b0, 1'b1);
        drive(1'b0, 1'b1, 1'b0, 1'b1);
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b1);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        press_ss();
        ticks(3);
        // Reset with start_stop low, first cycle after release high
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b1);
        ticks(4);

        // Randomized phase
        ss_l = 1'b0;
        clr_l = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 5) == 0)  ss_l = ~ss_l;
            if ($urandom_range(0, 59) == 0) clr_l = ~clr_l;
            if ($urandom_range(0, 19) == 0) pv = 16'($urandom);
            if ($urandom_range(0, 9) == 0)  pv = 16'($urandom_range(0, 5));
            rn = ($urandom_range(0, 299) != 0);
            tk = ($urandom_range(0, 2) != 0);
            drive(rn, ss_l, clr_l, tk);
        end

        idle(2);
        repeat (3) @(negedge clk);
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/bcd_timer_core.md
BCD_TIMER_CORE -- requirements
Module: bcd_timer_core

Interface
REQ-001 SHALL have parameter NRO_DIGITOS, default 4, number of BCD digits driven on num; only 4 is supported.
REQ-002 SHALL have parameter TICK_DIV, default 1, number of tick pulses per counted second; legal range is 1..255.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 tick  input  1  one-cycle enable pulse from the prescaler.
REQ-006 start_stop  input  1  debounced button level; acts on its rising edge.
REQ-007 clear  input  1  debounced button level; acts on its rising edge.
REQ-008 preset  input  BCDnumber_t[NRO_DIGITOS-1:0]  countdown start value, digits [3:0] = M-tens, M-units, S-tens, S-units.
REQ-009 num  output  BCDnumber_t[NRO_DIGITOS-1:0]  current MM:SS value in the same digit order, consumed directly by the digit selector.
REQ-010 running  output  1  high while the state is RUN.
REQ-011 done  output  1  one-cycle pulse on terminal count.

Function
REQ-012 SHALL implement the FSM states IDLE, RUN, PAUSE and DONE.
REQ-013 SHALL detect button edges as level high now and low in the previous cycle, using one register per button; the resulting action takes effect at the clock edge following the sampled edge.
REQ-014 Transitions on start_stop: IDLE->RUN, RUN->PAUSE, PAUSE->RUN; start_stop is ignored in DONE.
REQ-015 A clear edge in any state SHALL move the FSM to IDLE and set num to 00:00 in the same edge.
REQ-016 A prescale counter SHALL advance only on tick while in RUN; on the TICK_DIV-th tick it SHALL return to 0 and update num once.
REQ-017 The prescale counter SHALL be zeroed on entry to RUN from IDLE and SHALL be held, not zeroed, across PAUSE.
REQ-018 The count SHALL be in BCD, with seconds units 0..9, seconds tens 0..5, minutes units 0..9 and minutes tens 0..5; a carry or borrow ripples to the next digit within the same cycle.
REQ-019 Priority for simultaneous events SHALL be rst_n > clear > start_stop > tick; a tick coinciding with RUN->PAUSE SHALL be dropped.
REQ-020 running SHALL be high exactly in RUN, and num SHALL be registered with no combinational path from any input.

Reset
REQ-021 While rst_n=0 at a clock edge, the block SHALL load state IDLE, num=00:00, prescale=0, edge registers=0, running=0 and done=0.
REQ-022 A reset asserted mid-RUN SHALL discard the count, and the first button edge after release SHALL be detected only if its level was low during reset.

Configuration
REQ-023 Macro TIMER_COUNTDOWN_EN SHALL select the counting mode at compile time.
REQ-024 Undefined (count-up): num increments, 59:59 wraps to 00:00 with a done pulse in the wrap cycle, DONE is unreachable, and preset is unused.
REQ-025 Defined (countdown), behaviour on IDLE->RUN:
  - preset is loaded into num, with tens digits >5 clamped to 5 and units digits >9 clamped to 9;
  - if the clamped preset equals 00:00, the FSM goes to DONE with a done pulse and never enters RUN.
REQ-026 Defined (countdown), behaviour on terminal count:
  - the decrement that produces 00:00 SHALL move the FSM to DONE and pulse done in the same edge;
  - num then holds 00:00 until clear.

Structure
REQ-027 BCDnumber_t (4-bit BCD digit) and the FSM state enum SHALL reside in the shared package packs, alongside the constants SEC_TENS_MAX=5, MIN_TENS_MAX=5 and UNITS_MAX=9.
REQ-028 A sub-module bcd_digit_cnt SHALL be instantiated 4 times in a ripple chain, with:
  - parameter MAX;
  - inputs en, up, load, d;
  - outputs q, carry.

Verification
REQ-029 Count-up, TICK_DIV=1: reset, start_stop edge, then 60 ticks -> num=01:00, running=1, done=0.
REQ-030 Count-up wrap: run from 59:58 and apply 2 ticks -> num=00:00, done high for exactly 1 cycle, state stays RUN.
REQ-031 Pause: after 5 ticks, start_stop edge, 10 ticks, start_stop edge, 3 ticks -> num=00:08, with running low during the pause.
REQ-032 Simultaneity: clear, start_stop and tick all rising in the same cycle during RUN at 12:34 -> next cycle num=00:00, state IDLE, no count.
REQ-033 Countdown: preset=00:03, start_stop edge, 3 ticks -> num=00:00 and done pulses on the 3rd tick; a further start_stop edge is ignored; clear returns to IDLE.
REQ-034 Countdown edge cases:
  - preset=00:00 with start edge -> DONE plus a done pulse at once;
  - preset digits 7,C,9,F -> loaded value 59:59;
  - TICK_DIV=4 with 7 ticks -> count changes exactly once.
